// File: rtl/ex_hazard_unit.sv
// ex_hazard_unit
//
// Purpose: hazard detection and operand forwarding for the EX stage of a classic five-stage
// MIPS-style pipeline.
//   - It tracks the destinations of the instructions in MEM and WB with small shadow registers.
//   - It selects ALU operand sources for the instruction in EX.
//   - It detects a load-use hazard against the instruction in ID and inserts one stall/bubble
//     cycle for it.
//   - It counts the stall cycles taken, saturating at 0xFFFF.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_i          asynchronous active-high reset
//   id_valid_i     ID stage holds a real instruction
//   id_rs_i        rs field of the ID instruction
//   id_rt_i        rt field of the ID instruction
//   id_uses_rt_i   ID instruction reads rt
//   ex_RegWrite_i  RegWrite control of the EX instruction
//   ex_MemRead_i   MemRead control of the EX instruction (load)
//   ex_RegDst_i    EX destination select: 1 = rd, 0 = rt
//   ex_RS_i        rs field of the EX instruction
//   ex_RT_i        rt field of the EX instruction
//   ex_RD_i        rd field of the EX instruction
//   stall_o        hold PC and IF/ID
//   bubble_o       zero the controls entering ID/EX
//   fwdA_o         ALU operand A source: 00 regfile, 10 MEM, 01 WB
//   fwdB_o         ALU operand B source, same encoding
//   stall_cnt_o    stall cycles taken, saturating
module ex_hazard_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        ex_RegWrite_i,
  input  logic        ex_MemRead_i,
  input  logic        ex_RegDst_i,
  input  logic [4:0]  ex_RS_i,
  input  logic [4:0]  ex_RT_i,
  input  logic [4:0]  ex_RD_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic [1:0]  fwdA_o,
  output logic [1:0]  fwdB_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0]  FwdReg = 2'b00;
  localparam logic [1:0]  FwdMem = 2'b10;
  localparam logic [1:0]  FwdWb  = 2'b01;
  localparam logic [15:0] CntMax = 16'hFFFF;

  typedef enum logic {
    StRun   = 1'b0,
    StStall = 1'b1
  } stallState_e;

  // EX-stage destination decode.
  logic [4:0] exDst;
  logic       exWr;

  // Shadows of the writers now in MEM and WB.
  logic       memWrQ;
  logic       memLdQ;
  logic [4:0] memDstQ;
  logic       wbWrQ;
  logic [4:0] wbDstQ;

  stallState_e stallQ, stallD;
  logic        luh;
  logic        stallNow;
  logic [15:0] stallCntQ;

  assign exDst = ex_RegDst_i ? ex_RD_i : ex_RT_i;
  // $0 is hardwired, so a write to it is never a hazard or a forwarding source.
  assign exWr  = ex_RegWrite_i & (exDst != 5'd0);

  // The shadows advance every cycle, even during a stall: EX then holds the bubble
  // (exWr = 0), so MEM simply picks up a non-writer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memWrQ  <= 1'b0;
      memLdQ  <= 1'b0;
      memDstQ <= 5'd0;
      wbWrQ   <= 1'b0;
      wbDstQ  <= 5'd0;
    end else begin
      memWrQ  <= exWr;
      memLdQ  <= ex_MemRead_i;
      memDstQ <= exDst;
      wbWrQ   <= memWrQ;
      wbDstQ  <= memDstQ;
    end
  end

  // Operand source selection.
  // - MEM wins over WB because it holds the younger value.
  // - A load in MEM has no data yet, so that case falls through to the WB check.
  always_comb begin
    fwdA_o = FwdReg;
    if (memWrQ && !memLdQ && (memDstQ == ex_RS_i)) begin
      fwdA_o = FwdMem;
    end else if (wbWrQ && (wbDstQ == ex_RS_i)) begin
      fwdA_o = FwdWb;
    end
  end

  always_comb begin
    fwdB_o = FwdReg;
    if (memWrQ && !memLdQ && (memDstQ == ex_RT_i)) begin
      fwdB_o = FwdMem;
    end else if (wbWrQ && (wbDstQ == ex_RT_i)) begin
      fwdB_o = FwdWb;
    end
  end

  // Load-use: the load in EX writes a register that the ID instruction reads.
  assign luh = id_valid_i & ex_MemRead_i & exWr &
               ((exDst == id_rs_i) | (id_uses_rt_i & (exDst == id_rt_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallQ <= StRun;
    end else begin
      stallQ <= stallD;
    end
  end

  // STALL always returns to RUN.
  // - The cycle after a stall, EX holds the bubble, so luh cannot be re-raised by the same
  //   load. Each hazard therefore costs exactly one cycle.
  // - Reset gates the output so that hazardous inputs seen during reset cannot stall.
  always_comb begin
    stallD   = stallQ;
    stallNow = 1'b0;
    unique case (stallQ)
      StRun: begin
        stallNow = luh & ~rst_i;
        if (luh) begin
          stallD = StStall;
        end
      end
      StStall: begin
        stallD = StRun;
      end
    endcase
  end

  assign stall_o  = stallNow;
  assign bubble_o = stallNow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCntQ <= 16'd0;
    end else if (stallNow && (stallCntQ != CntMax)) begin
      stallCntQ <= stallCntQ + 16'd1;
    end
  end

  assign stall_cnt_o = stallCntQ;

endmodule

// File: tb/tb_ex_hazard_unit.sv
module tb_ex_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid;
  logic [4:0]  idRs, idRt;
  logic        idUsesRt;
  logic        exRegWrite, exMemRead, exRegDst;
  logic [4:0]  exRs, exRt, exRd;
  logic        stall, bubble;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stallCnt;

  int total = 0;
  int bad = 0;

  ex_hazard_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (idValid),
    .id_rs_i      (idRs),
    .id_rt_i      (idRt),
    .id_uses_rt_i (idUsesRt),
    .ex_RegWrite_i(exRegWrite),
    .ex_MemRead_i (exMemRead),
    .ex_RegDst_i  (exRegDst),
    .ex_RS_i      (exRs),
    .ex_RT_i      (exRt),
    .ex_RD_i      (exRd),
    .stall_o      (stall),
    .bubble_o     (bubble),
    .fwdA_o       (fwdA),
    .fwdB_o       (fwdB),
    .stall_cnt_o  (stallCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the pipeline: the register written by the instruction that left EX one cycle
  // ago (now in MEM) and two cycles ago (now in WB), whether the last cycle was a stall, and
  // how many stalls have happened since the last reset.
  typedef struct packed {
    logic       writes;
    logic       isLoad;
    logic [4:0] dst;
  } instr_t;

  instr_t age1, age2;
  logic   stalledLast;
  int     stallsSeen;
  int     cntOffset = 0;

  function automatic instr_t exInstr();
    instr_t r;
    r.dst    = exRegDst ? exRd : exRt;
    r.writes = exRegWrite && (r.dst != 0);
    r.isLoad = exMemRead;
    return r;
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] src);
    if (rst) return 2'b00;
    if (age1.writes && !age1.isLoad && age1.dst == src) return 2'b10;
    if (age2.writes && age2.dst == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic expStall();
    instr_t e;
    e = exInstr();
    if (rst || stalledLast || !idValid || !e.isLoad || !e.writes) return 1'b0;
    return (e.dst == idRs) || (idUsesRt && e.dst == idRt);
  endfunction

  function automatic int expCnt();
    int v;
    v = cntOffset + stallsSeen;
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age1        <= '0;
      age2        <= '0;
      stalledLast <= 1'b0;
      stallsSeen  <= 0;
    end else begin
      age2        <= age1;
      age1        <= exInstr();
      stalledLast <= expStall();
      if (expStall()) stallsSeen <= stallsSeen + 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_stall", 32'(stall), 32'(expStall()));
    check("cyc_bubble", 32'(bubble), 32'(expStall()));
    check("cyc_fwdA", 32'(fwdA), 32'(expFwd(exRs)));
    check("cyc_fwdB", 32'(fwdB), 32'(expFwd(exRt)));
    check("cyc_cnt", 32'(stallCnt), 32'(rst ? 0 : expCnt()));
  end

  task automatic setEx(input logic rw, input logic mr, input logic rd_sel,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exRegWrite = rw;
    exMemRead  = mr;
    exRegDst   = rd_sel;
    exRs       = rs;
    exRt       = rt;
    exRd       = rd;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut);
    idValid  = v;
    idRs     = rs;
    idRt     = rt;
    idUsesRt = ut;
  endtask

  task automatic nop();
    setEx(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    setId(1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with hazardous inputs present.
    rst = 1'b1;
    setEx(1'b1, 1'b1, 1'b0, 5'd4, 5'd4, 5'd0);
    setId(1'b1, 5'd4, 5'd4, 1'b1);
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bubble", 32'(bubble), 32'd0);
    check("rst_fwdA", 32'(fwdA), 32'd0);
    check("rst_fwdB", 32'(fwdB), 32'd0);
    check("rst_cnt", 32'(stallCnt), 32'd0);
    tick();
    tick();
    nop();
    rst = 1'b0;
    tick();

    // ALU chain: add $3, then reader of $3 on A (MEM), then reader on B (WB).
    setEx(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    tick();
    setEx(1'b1, 1'b0, 1'b1, 5'd3, 5'd7, 5'd8);
    #1;
    check("alu_memA", 32'(fwdA), 32'b10);
    check("alu_memB", 32'(fwdB), 32'b00);
    tick();
    setEx(1'b0, 1'b0, 1'b0, 5'd9, 5'd3, 5'd0);
    #1;
    check("alu_wbB", 32'(fwdB), 32'b01);
    check("alu_wbA", 32'(fwdA), 32'b00);
    tick();

    // Double match: MEM priority.
    setEx(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    setEx(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    setEx(1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0);
    #1;
    check("dbl_A", 32'(fwdA), 32'b10);
    check("dbl_B", 32'(fwdB), 32'b10);
    tick();

    // Load in MEM is never forwarded from MEM; it arrives from WB a cycle later.
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd6, 5'd0);
    tick();
    setEx(1'b0, 1'b0, 1'b0, 5'd6, 5'd6, 5'd0);
    #1;
    check("ldmem_A", 32'(fwdA), 32'b00);
    tick();
    #1;
    check("ldwb_A", 32'(fwdA), 32'b01);
    tick();
    nop();
    tick();
    tick();

    // Load-use on rs.
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
    setId(1'b1, 5'd4, 5'd9, 1'b0);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_bubble", 32'(bubble), 32'd1);
    check("lu_cnt0", 32'(stallCnt), 32'd0);
    tick();
    setEx(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("lu_once", 32'(stall), 32'd0);
    check("lu_cnt1", 32'(stallCnt), 32'd1);
    tick();
    setEx(1'b1, 1'b0, 1'b1, 5'd4, 5'd9, 5'd10);
    setId(1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    check("lu_fwdA", 32'(fwdA), 32'b01);
    check("lu_fwdB", 32'(fwdB), 32'b00);
    tick();
    nop();

    // rt dependence only counts when the ID instruction reads rt.
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
    setId(1'b1, 5'd2, 5'd7, 1'b0);
    #1;
    check("rt_unused", 32'(stall), 32'd0);
    setId(1'b1, 5'd2, 5'd7, 1'b1);
    #1;
    check("rt_used", 32'(stall), 32'd1);
    tick();
    nop();
    tick();

    // Invalid ID never stalls.
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
    setId(1'b0, 5'd4, 5'd4, 1'b1);
    #1;
    check("inval_stall", 32'(stall), 32'd0);
    tick();

    // Register 0 is neither a hazard nor a forwarding source.
    setEx(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    setId(1'b1, 5'd0, 5'd0, 1'b1);
    tick();
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_stall", 32'(stall), 32'd0);
    check("r0_fwdA", 32'(fwdA), 32'b00);
    check("r0_fwdB", 32'(fwdB), 32'b00);
    tick();
    nop();
    tick();

    // A hazard held across cycles stalls at most every other cycle.
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
    setId(1'b1, 5'd4, 5'd0, 1'b0);
    #1;
    check("held_1", 32'(stall), 32'd1);
    tick();
    check("held_2", 32'(stall), 32'd0);
    tick();
    check("held_3", 32'(stall), 32'd1);
    tick();
    nop();
    tick();

    // Asynchronous reset in the middle of a stall cycle.
    setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
    setId(1'b1, 5'd4, 5'd0, 1'b0);
    #1;
    check("mid_pre", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    cntOffset = 0;
    #1;
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_bubble", 32'(bubble), 32'd0);
    check("mid_cnt", 32'(stallCnt), 32'd0);
    check("mid_fwdB", 32'(fwdB), 32'b00);
    tick();
    nop();
    rst = 1'b0;
    setEx(1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0);
    #1;
    check("post_fwdA", 32'(fwdA), 32'b00);
    check("post_fwdB", 32'(fwdB), 32'b00);
    tick();
    nop();
    tick();

    // Saturation: preload the counter just below the ceiling, then take three stalls.
    force dut.stallCntQ = 16'hFFFE;
    cntOffset = 65534 - stallsSeen;
    #1;
    release dut.stallCntQ;
    #1;
    check("sat_pre", 32'(stallCnt), 32'hFFFE);
    tick();
    for (int i = 0; i < 3; i++) begin
      setEx(1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
      setId(1'b1, 5'd4, 5'd0, 1'b0);
      #1;
      check("sat_stall", 32'(stall), 32'd1);
      tick();
      nop();
      tick();
    end
    check("sat_cnt", 32'(stallCnt), 32'hFFFF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
